// File: rtl/stack_sequencer_if.sv
// Memory-side request/acknowledge bus of the stack sequencer.
// The master drives the registered request; the slave answers with ack and read data.
interface stack_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              o_Mem_Req;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_Wdata;
  logic              i_Mem_Ack;
  logic [DATA_W-1:0] i_Mem_Rdata;

  modport master (
    output o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata,
    input  i_Mem_Ack, i_Mem_Rdata
  );

  modport slave (
    input  o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata,
    output i_Mem_Ack, i_Mem_Rdata
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack-operation sequencer: owns SP and runs CALL/RET/RST/PUSH/POP/RETI
// over a wait-state tolerant memory handshake, returning the new PC.
module stack_sequencer #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = 16'hFFFE
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic                i_Start,
  input  logic [2:0]          i_Op,
  input  logic                i_Cond_Met,
  input  logic [ADDR_W-1:0]   i_Target,
  input  logic [2:0]          i_Vector,
  input  logic [ADDR_W-1:0]   i_PC,
  input  logic [2*DATA_W-1:0] i_Push_Data,
  input  logic                i_SP_Load,
  input  logic [ADDR_W-1:0]   i_SP_Value,
  stack_sequencer_if.master   mem,
  output logic                o_Busy,
  output logic                o_Done,
  output logic                o_PC_Load,
  output logic [ADDR_W-1:0]   o_PC_Value,
  output logic [2*DATA_W-1:0] o_Pop_Data,
  output logic                o_IME_Set,
  output logic                o_Skipped,
  output logic                o_Illegal,
  output logic [ADDR_W-1:0]   o_SP
);

  localparam logic [2:0] OP_CALL = 3'd0;
  localparam logic [2:0] OP_RET  = 3'd1;
  localparam logic [2:0] OP_RST  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;
  localparam logic [2:0] OP_RETI = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI, S_FIN, S_DONE
  } state_t;

  state_t              r_State, w_Next_State;
  logic [2:0]          r_Op;
  logic                r_Skip, r_Ill;
  logic [ADDR_W-1:0]   r_SP, w_SP_Next;
  logic [ADDR_W-1:0]   r_PC_Value;
  logic [2*DATA_W-1:0] r_Pop_Data, r_Word;
  logic                r_Mem_Req, r_Mem_We;
  logic [ADDR_W-1:0]   r_Mem_Addr;
  logic [DATA_W-1:0]   r_Mem_Wdata;
  logic                w_Ack, w_Accept, w_Start_Skip, w_Start_Ill, w_Next_Access;

  // An ack only counts while a request is actually outstanding.
  assign w_Ack        = r_Mem_Req & mem.i_Mem_Ack;
  assign w_Accept     = (r_State == S_IDLE) & i_Start & ~i_SP_Load;
  assign w_Start_Skip = ((i_Op == OP_CALL) | (i_Op == OP_RET)) & ~i_Cond_Met;
  assign w_Start_Ill  = (i_Op > OP_RETI);
  assign w_Next_Access = (w_Next_State == S_WR_HI) | (w_Next_State == S_WR_LO) |
                         (w_Next_State == S_RD_LO) | (w_Next_State == S_RD_HI);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) r_State <= S_IDLE;
    else            r_State <= w_Next_State;
  end

  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      S_IDLE: begin
        if (w_Accept) begin
          if (w_Start_Ill || w_Start_Skip)                          w_Next_State = S_DONE;
          else if (i_Op == OP_CALL || i_Op == OP_RST || i_Op == OP_PUSH) w_Next_State = S_DEC;
          else                                                      w_Next_State = S_RD_LO;
        end
      end
      S_DEC:   w_Next_State = S_WR_HI;
      S_WR_HI: if (w_Ack) w_Next_State = S_WR_LO;
      S_WR_LO: if (w_Ack) w_Next_State = S_DONE;
      S_RD_LO: if (w_Ack) w_Next_State = S_RD_HI;
      S_RD_HI: if (w_Ack) w_Next_State = (r_Op == OP_POP) ? S_DONE : S_FIN;
      S_FIN:   w_Next_State = S_DONE;
      S_DONE:  w_Next_State = S_IDLE;
      default: w_Next_State = S_IDLE;
    endcase
  end

  always_comb begin
    o_Busy    = (r_State != S_IDLE);
    o_Done    = (r_State == S_DONE);
    o_PC_Load = o_Done & ~r_Skip & ~r_Ill & (r_Op != OP_PUSH) & (r_Op != OP_POP);
    o_IME_Set = o_Done & ~r_Ill & (r_Op == OP_RETI);
    o_Skipped = o_Done & r_Skip;
    o_Illegal = o_Done & r_Ill;
  end

  // SP arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    w_SP_Next = r_SP;
    case (r_State)
      S_IDLE:          if (i_SP_Load) w_SP_Next = i_SP_Value;
      S_DEC:           w_SP_Next = r_SP - 1'b1;
      S_WR_HI:         if (w_Ack) w_SP_Next = r_SP - 1'b1;
      S_RD_LO, S_RD_HI: if (w_Ack) w_SP_Next = r_SP + 1'b1;
      default:         w_SP_Next = r_SP;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_Accept)
      r_Word <= (i_Op == OP_PUSH) ? i_Push_Data : (2*DATA_W)'(i_PC);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Op        <= OP_CALL;
      r_Skip      <= 1'b0;
      r_Ill       <= 1'b0;
      r_SP        <= SP_RESET;
      r_PC_Value  <= '0;
      r_Pop_Data  <= '0;
      r_Mem_Req   <= 1'b0;
      r_Mem_We    <= 1'b0;
      r_Mem_Addr  <= '0;
      r_Mem_Wdata <= '0;
    end else begin
      r_SP <= w_SP_Next;
      if (w_Accept) begin
        r_Op   <= i_Op;
        r_Skip <= w_Start_Skip;
        r_Ill  <= w_Start_Ill;
        if (i_Op == OP_CALL)     r_PC_Value <= i_Target;
        else if (i_Op == OP_RST) r_PC_Value <= ADDR_W'({i_Vector, 3'b000});
      end
      if (r_State == S_RD_LO && w_Ack) r_Pop_Data[DATA_W-1:0] <= mem.i_Mem_Rdata;
      if (r_State == S_RD_HI && w_Ack) begin
        r_Pop_Data[2*DATA_W-1:DATA_W] <= mem.i_Mem_Rdata;
        if (r_Op != OP_POP) r_PC_Value <= ADDR_W'({mem.i_Mem_Rdata, r_Pop_Data[DATA_W-1:0]});
      end
      // Request fields are loaded on entry to an access state and frozen through its waits.
      r_Mem_Req <= w_Next_Access;
      if (w_Next_Access) begin
        r_Mem_Addr  <= w_SP_Next;
        r_Mem_We    <= (w_Next_State == S_WR_HI) | (w_Next_State == S_WR_LO);
        r_Mem_Wdata <= (w_Next_State == S_WR_HI) ? r_Word[2*DATA_W-1:DATA_W] : r_Word[DATA_W-1:0];
      end
    end
  end

  assign mem.o_Mem_Req   = r_Mem_Req;
  assign mem.o_Mem_We    = r_Mem_We;
  assign mem.o_Mem_Addr  = r_Mem_Addr;
  assign mem.o_Mem_Wdata = r_Mem_Wdata;
  assign o_PC_Value      = r_PC_Value;
  assign o_Pop_Data      = r_Pop_Data;
  assign o_SP            = r_SP;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a reference stack model queues expected
// memory accesses and completions; a wait-state memory responder checks them.
module tb_stack_sequencer;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic          i_Start = 1'b0;
  logic [2:0]    i_Op = '0;
  logic          i_Cond_Met = 1'b1;
  logic [AW-1:0] i_Target = '0;
  logic [2:0]    i_Vector = '0;
  logic [AW-1:0] i_PC = '0;
  logic [2*DW-1:0] i_Push_Data = '0;
  logic          i_SP_Load = 1'b0;
  logic [AW-1:0] i_SP_Value = '0;
  logic          o_Busy, o_Done, o_PC_Load, o_IME_Set, o_Skipped, o_Illegal;
  logic [AW-1:0] o_PC_Value, o_SP;
  logic [2*DW-1:0] o_Pop_Data;

  always #5 i_Clk = ~i_Clk;

  stack_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  stack_sequencer #(.ADDR_W(AW), .DATA_W(DW), .SP_RESET(16'hFFFE)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Start(i_Start), .i_Op(i_Op),
    .i_Cond_Met(i_Cond_Met), .i_Target(i_Target), .i_Vector(i_Vector), .i_PC(i_PC),
    .i_Push_Data(i_Push_Data), .i_SP_Load(i_SP_Load), .i_SP_Value(i_SP_Value),
    .mem(bus), .o_Busy(o_Busy), .o_Done(o_Done), .o_PC_Load(o_PC_Load),
    .o_PC_Value(o_PC_Value), .o_Pop_Data(o_Pop_Data), .o_IME_Set(o_IME_Set),
    .o_Skipped(o_Skipped), .o_Illegal(o_Illegal), .o_SP(o_SP)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    logic        pc_load;
    logic [15:0] pc;
    logic        is_pop;
    logic [15:0] pop;
    logic        ime;
    logic        skip;
    logic        ill;
    logic [15:0] sp;
    int          lat;
  } done_t;

  acc_t        aq[$];
  done_t       dq[$];
  bit [7:0]    mem [65536];
  bit [7:0]    mdl [65536];
  logic [15:0] m_sp;
  int          wait_cfg = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after wait_cfg idle cycles, checks hold and scoreboard.
  initial begin
    int         wcnt;
    logic [15:0] h_addr;
    logic       h_we;
    logic [7:0] h_wd;
    acc_t       a;
    wcnt = 0;
    bus.i_Mem_Ack   = 1'b0;
    bus.i_Mem_Rdata = '0;
    forever begin
      @(negedge i_Clk);
      if (!i_Reset_n || !bus.o_Mem_Req) begin
        bus.i_Mem_Ack = 1'b0;
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          h_addr = bus.o_Mem_Addr; h_we = bus.o_Mem_We; h_wd = bus.o_Mem_Wdata;
        end else begin
          check("hold_addr", bus.o_Mem_Addr, h_addr);
          check("hold_we", bus.o_Mem_We, h_we);
          if (h_we) check("hold_wdata", bus.o_Mem_Wdata, h_wd);
        end
        if (wcnt >= wait_cfg) begin
          bus.i_Mem_Ack   = 1'b1;
          bus.i_Mem_Rdata = mem[bus.o_Mem_Addr];
          if (aq.size() == 0) check("spurious_req", bus.o_Mem_Req, 1'b0);
          else begin
            a = aq.pop_front();
            check("acc_we", bus.o_Mem_We, a.we);
            check("acc_addr", bus.o_Mem_Addr, a.addr);
            if (a.we) check("acc_wdata", bus.o_Mem_Wdata, a.data);
          end
          if (bus.o_Mem_We) mem[bus.o_Mem_Addr] = bus.o_Mem_Wdata;
          wcnt = 0;
        end else begin
          bus.i_Mem_Ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  task automatic model(input logic [2:0] op, input logic cond, input logic [15:0] tgt,
                       input logic [2:0] vec, input logic [15:0] pc, input logic [15:0] pd,
                       input int w);
    done_t e;
    acc_t  a;
    logic [15:0] word, a1, a2;
    e = '{pc_load: 1'b0, pc: '0, is_pop: 1'b0, pop: '0, ime: 1'b0, skip: 1'b0,
          ill: 1'b0, sp: '0, lat: 1};
    if (op > 3'd5) e.ill = 1'b1;
    else if ((op == 3'd0 || op == 3'd1) && !cond) e.skip = 1'b1;
    else if (op == 3'd0 || op == 3'd2 || op == 3'd3) begin
      word = (op == 3'd3) ? pd : pc;
      a1 = m_sp - 16'd1;
      a2 = m_sp - 16'd2;
      a.we = 1'b1; a.addr = a1; a.data = word[15:8]; aq.push_back(a);
      a.we = 1'b1; a.addr = a2; a.data = word[7:0];  aq.push_back(a);
      mdl[a1] = word[15:8];
      mdl[a2] = word[7:0];
      m_sp = a2;
      e.lat = 4 + 2 * w;
      if (op != 3'd3) begin
        e.pc_load = 1'b1;
        e.pc = (op == 3'd0) ? tgt : {10'b0, vec, 3'b000};
      end
    end else begin
      a1 = m_sp;
      a2 = m_sp + 16'd1;
      word = {mdl[a2], mdl[a1]};
      a.we = 1'b0; a.addr = a1; a.data = '0; aq.push_back(a);
      a.we = 1'b0; a.addr = a2; a.data = '0; aq.push_back(a);
      m_sp = a2 + 16'd1;
      if (op == 3'd4) begin
        e.is_pop = 1'b1; e.pop = word; e.lat = 3 + 2 * w;
      end else begin
        e.pc_load = 1'b1; e.pc = word; e.ime = (op == 3'd5); e.lat = 4 + 2 * w;
      end
    end
    e.sp = m_sp;
    dq.push_back(e);
  endtask

  task automatic drive_start(input logic [2:0] op, input logic cond, input logic [15:0] tgt,
                             input logic [2:0] vec, input logic [15:0] pc, input logic [15:0] pd);
    @(negedge i_Clk);
    i_Op = op; i_Cond_Met = cond; i_Target = tgt; i_Vector = vec; i_PC = pc;
    i_Push_Data = pd; i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic cond, input logic [15:0] tgt,
                        input logic [2:0] vec, input logic [15:0] pc, input logic [15:0] pd,
                        input int w);
    done_t e;
    int    acc;
    bit    seen;
    model(op, cond, tgt, vec, pc, pd, w);
    wait_cfg = w;
    drive_start(op, cond, tgt, vec, pc, pd);
    acc = cyc;
    check("busy", o_Busy, 1'b1);
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (k > 0) @(negedge i_Clk);
      if (o_Done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", o_Done, 1'b1);
      void'(dq.pop_front());
      aq.delete();
    end else begin
      e = dq.pop_front();
      check("latency", cyc - acc + 1, e.lat);
      check("pc_load", o_PC_Load, e.pc_load);
      if (e.pc_load) check("pc_value", o_PC_Value, e.pc);
      if (e.is_pop) check("pop_data", o_Pop_Data, e.pop);
      check("ime_set", o_IME_Set, e.ime);
      check("skipped", o_Skipped, e.skip);
      check("illegal", o_Illegal, e.ill);
      check("sp", o_SP, e.sp);
      check("acc_left", aq.size(), 0);
    end
  endtask

  task automatic load_sp(input logic [15:0] v);
    @(negedge i_Clk);
    i_SP_Load = 1'b1; i_SP_Value = v;
    @(negedge i_Clk);
    i_SP_Load = 1'b0;
    check("sp_load", o_SP, v);
    m_sp = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    m_sp = 16'hFFFE;
    repeat (2) @(negedge i_Clk);
    check("rst_sp", o_SP, 16'hFFFE);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_req", bus.o_Mem_Req, 1'b0);
    check("rst_done", o_Done, 1'b0);
    check("rst_pc", o_PC_Value, 16'h0000);
    check("rst_pop", o_Pop_Data, 16'h0000);
    i_Reset_n = 1'b1;

    run_op(3'd0, 1'b1, 16'h1234, 3'd0, 16'h0150, 16'h0000, 0);  // CALL
    run_op(3'd1, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 2);  // RET, 2 waits
    run_op(3'd3, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0777, 0);  // PUSH
    run_op(3'd5, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 1);  // RETI
    run_op(3'd2, 1'b1, 16'h0000, 3'd7, 16'h0200, 16'h0000, 0);  // RST 7
    run_op(3'd4, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 1);  // POP
    run_op(3'd0, 1'b0, 16'h5555, 3'd0, 16'h0AAA, 16'h0000, 0);  // CALL cc false
    run_op(3'd1, 1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 0);  // RET cc false
    run_op(3'd6, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 0);  // illegal
    run_op(3'd7, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 0);  // illegal

    load_sp(16'h0001);
    run_op(3'd3, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'hABCD, 1);  // PUSH across wrap
    run_op(3'd4, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 0);  // POP across wrap

    // SP load and start in the same IDLE cycle: the load wins.
    @(negedge i_Clk);
    i_SP_Load = 1'b1; i_SP_Value = 16'h1000;
    i_Start = 1'b1; i_Op = 3'd0; i_Cond_Met = 1'b1;
    @(negedge i_Clk);
    i_SP_Load = 1'b0; i_Start = 1'b0;
    m_sp = 16'h1000;
    check("ld_win_sp", o_SP, 16'h1000);
    for (int k = 0; k < 3; k++) begin
      check("ld_win_busy", o_Busy, 1'b0);
      @(negedge i_Clk);
    end

    // Reset while the low byte write is waiting for its ack.
    model(3'd0, 1'b1, 16'h4321, 3'd0, 16'h0BEE, 16'h0000, 3);
    wait_cfg = 3;
    drive_start(3'd0, 1'b1, 16'h4321, 3'd0, 16'h0BEE, 16'h0000);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (bus.o_Mem_Req && bus.o_Mem_Addr == 16'h0FFE) found = 1;
      else @(negedge i_Clk);
    end
    if (!found) check("reach_wr_lo", bus.o_Mem_Addr, 16'h0FFE);
    i_Reset_n = 1'b0;
    #1;
    check("abort_done", o_Done, 1'b0);
    check("abort_sp", o_SP, 16'hFFFE);
    check("abort_req", bus.o_Mem_Req, 1'b0);
    check("abort_busy", o_Busy, 1'b0);
    aq.delete();
    dq.delete();
    m_sp = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_Clk);
      check("abort_no_done", o_Done, 1'b0);
    end
    i_Reset_n = 1'b1;

    run_op(3'd3, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h1357, 1);  // PUSH after abort
    run_op(3'd4, 1'b1, 16'h0000, 3'd0, 16'h0000, 16'h0000, 2);  // POP

    repeat (2) @(negedge i_Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
